// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris game-flow sequencer: datapath command
// codes, game-state output codes, FSM state type and line-clear scoring.
// Optional macro TETRIS_PAUSE_EN adds the PAUSED state to the FSM type.
package tetris_pkg;

    // Commands sent to the board-occupancy datapath
    localparam logic [2:0] CMD_RESET_BOARD = 3'd0;
    localparam logic [2:0] CMD_SPAWN       = 3'd1;
    localparam logic [2:0] CMD_LEFT        = 3'd2;
    localparam logic [2:0] CMD_RIGHT       = 3'd3;
    localparam logic [2:0] CMD_ROT         = 3'd4;
    localparam logic [2:0] CMD_DOWN        = 3'd5;
    localparam logic [2:0] CMD_LOCK        = 3'd6;

    // Game state as seen by the pixel colour mapper
    localparam logic [1:0] ST_COVER = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_END   = 2'd2;

    // Points awarded for 0..4 cleared lines
    localparam logic [15:0] SCORE_L0 = 16'd0;
    localparam logic [15:0] SCORE_L1 = 16'd1;
    localparam logic [15:0] SCORE_L2 = 16'd3;
    localparam logic [15:0] SCORE_L3 = 16'd5;
    localparam logic [15:0] SCORE_L4 = 16'd8;

    typedef enum logic [2:0] {
        FSM_COVER     = 3'd0,
        FSM_RST_ISSUE = 3'd1,
        FSM_SPAWN     = 3'd2,
        FSM_IDLE      = 3'd3,
        FSM_WAIT      = 3'd4,
        FSM_LOCK      = 3'd5,
        FSM_OVER      = 3'd6
`ifdef TETRIS_PAUSE_EN
        ,
        FSM_PAUSED    = 3'd7
`endif
    } fsm_t;

    // Points for a LOCK response; anything above four lines scores as four
    function automatic logic [15:0] score_points(input logic [2:0] lines);
        logic [15:0] pts;
        case (lines)
            3'd0:    pts = SCORE_L0;
            3'd1:    pts = SCORE_L1;
            3'd2:    pts = SCORE_L2;
            3'd3:    pts = SCORE_L3;
            default: pts = SCORE_L4;
        endcase
        return pts;
    endfunction

    // Saturating score update
    function automatic logic [15:0] score_add(input logic [15:0] score, input logic [2:0] lines);
        logic [16:0] sum;
        sum = {1'b0, score} + {1'b0, score_points(lines)};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Only the cover and game-over screens differ; every other state is play
    function automatic logic [1:0] state_code(input fsm_t s);
        logic [1:0] code;
        case (s)
            FSM_COVER: code = ST_COVER;
            FSM_OVER:  code = ST_END;
            default:   code = ST_PLAY;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/shape_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) and the mapping of
// its low bits onto the seven tetromino shape codes 0..6.
module shape_lfsr #(
    parameter logic [7:0] LFSR_SEED = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] shape
);

    logic [7:0] r_lfsr;
    logic       w_feedback;

    assign w_feedback = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // Advance the LFSR every clock so the spawned shape depends on player timing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_feedback};
        end
    end

    // Code 7 is not a shape; fold it onto 0..3 using two other LFSR bits
    assign shape = (r_lfsr[2:0] != 3'd7) ? r_lfsr[2:0] : {1'b0, r_lfsr[4:3]};

endmodule

// File: rtl/tetris_flow_ctrl.sv
// Tetris game-flow sequencer: game state, shape selection, gravity, key
// latching, one-outstanding command/response handshake to the board
// datapath and a saturating score.
// Optional macro TETRIS_PAUSE_EN: key_start in IDLE pauses the game.
module tetris_flow_ctrl
    import tetris_pkg::*;
#(
    parameter int         DROP_FRAMES = 30,
    parameter logic [7:0] LFSR_SEED   = 8'h01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_start,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_rot,
    input  logic        key_down,
    input  logic        frame_end,
    output logic        cmd_valid,
    output logic [2:0]  cmd,
    input  logic        cmd_ready,
    input  logic        rsp_valid,
    input  logic        rsp_ok,
    input  logic [2:0]  rsp_lines,
    output logic [1:0]  state,
    output logic [2:0]  shape,
    output logic [15:0] score
);

    localparam int            CW        = $clog2(DROP_FRAMES);
    localparam logic [CW-1:0] GRAV_LAST = CW'(DROP_FRAMES - 1);

    fsm_t          r_fsm;
    logic          r_cmd_valid;
    logic [2:0]    r_cmd;
    logic [1:0]    r_state;
    logic [2:0]    r_shape;
    logic [15:0]   r_score;
    logic          r_issued;     // command of the current issue state already driven
    logic          r_wait_rsp;   // accepted, response not yet seen
    logic          r_left_pend;
    logic          r_right_pend;
    logic          r_rot_pend;
    logic          r_down_pend;
    logic          r_drop_pend;
    logic [CW-1:0] r_grav_cnt;
`ifdef TETRIS_PAUSE_EN
    logic          r_start_pend;
`endif

    logic [2:0]    w_lfsr_shape;
    logic          w_play;
    logic          w_accept;
    logic          w_rsp;
    logic          w_frame_step;
    logic          w_grav_wrap;

    shape_lfsr #(
        .LFSR_SEED (LFSR_SEED)
    ) u_shape_lfsr (
        .clk   (clk),
        .rst   (rst),
        .shape (w_lfsr_shape)
    );

    // States in which keys are latched and gravity runs (PAUSED is excluded)
    assign w_play = (r_fsm == FSM_SPAWN) || (r_fsm == FSM_IDLE) ||
                    (r_fsm == FSM_WAIT)  || (r_fsm == FSM_LOCK);

    // A response counts only for an accepted command, including same-cycle accept
    assign w_accept     = r_cmd_valid && cmd_ready;
    assign w_rsp        = rsp_valid && (w_accept || r_wait_rsp);
    assign w_frame_step = w_play && frame_end;
    assign w_grav_wrap  = w_frame_step && (r_grav_cnt == GRAV_LAST);

    // Game FSM with registered command, state, shape and score outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm        <= FSM_COVER;
            r_cmd_valid  <= 1'b0;
            r_cmd        <= CMD_RESET_BOARD;
            r_state      <= ST_COVER;
            r_shape      <= 3'd0;
            r_score      <= 16'd0;
            r_issued     <= 1'b0;
            r_wait_rsp   <= 1'b0;
            r_left_pend  <= 1'b0;
            r_right_pend <= 1'b0;
            r_rot_pend   <= 1'b0;
            r_down_pend  <= 1'b0;
            r_drop_pend  <= 1'b0;
            r_grav_cnt   <= '0;
`ifdef TETRIS_PAUSE_EN
            r_start_pend <= 1'b0;
`endif
        end else begin
            r_state <= state_code(r_fsm);

            if (w_accept) begin
                r_cmd_valid <= 1'b0;
                r_wait_rsp  <= ~rsp_valid;
            end else if (r_wait_rsp && rsp_valid) begin
                r_wait_rsp  <= 1'b0;
            end

            // Later assignments in the case below (flag clear on issue) win
            if (w_play) begin
                r_left_pend  <= r_left_pend  | key_left;
                r_right_pend <= r_right_pend | key_right;
                r_rot_pend   <= r_rot_pend   | key_rot;
                r_down_pend  <= r_down_pend  | key_down;
            end

            if (w_frame_step) begin
                if (w_grav_wrap) begin
                    r_grav_cnt  <= '0;
                    r_drop_pend <= 1'b1;
                end else begin
                    r_grav_cnt  <= r_grav_cnt + CW'(1);
                end
            end

            case (r_fsm)
                FSM_COVER: begin
                    r_grav_cnt <= '0;
                    if (key_start) begin
                        r_fsm <= FSM_RST_ISSUE;
                    end
                end

                FSM_RST_ISSUE: begin
                    if (!r_issued) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd       <= CMD_RESET_BOARD;
                        r_issued    <= 1'b1;
                        r_score     <= 16'd0;
                    end else if (w_rsp) begin
                        r_issued <= 1'b0;
                        r_fsm    <= FSM_SPAWN;
                    end
                end

                FSM_SPAWN: begin
                    if (!r_issued) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd       <= CMD_SPAWN;
                        r_issued    <= 1'b1;
                        r_shape     <= w_lfsr_shape;
                    end else if (w_rsp) begin
                        r_issued <= 1'b0;
                        if (rsp_ok) begin
                            r_fsm <= FSM_IDLE;
                        end else begin
                            r_fsm        <= FSM_OVER;
                            r_left_pend  <= 1'b0;
                            r_right_pend <= 1'b0;
                            r_rot_pend   <= 1'b0;
                            r_down_pend  <= 1'b0;
                            r_drop_pend  <= 1'b0;
`ifdef TETRIS_PAUSE_EN
                            r_start_pend <= 1'b0;
`endif
                        end
                    end
                end

                FSM_IDLE: begin
`ifdef TETRIS_PAUSE_EN
                    if (key_start || r_start_pend) begin
                        r_start_pend <= 1'b0;
                        r_fsm        <= FSM_PAUSED;
                    end else
`endif
                    if (r_drop_pend || r_down_pend) begin
                        // Gravity and a manual drop merge into one DOWN
                        r_cmd_valid <= 1'b1;
                        r_cmd       <= CMD_DOWN;
                        r_drop_pend <= w_grav_wrap;
                        r_down_pend <= key_down;
                        r_fsm       <= FSM_WAIT;
                    end else if (r_rot_pend) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd       <= CMD_ROT;
                        r_rot_pend  <= key_rot;
                        r_fsm       <= FSM_WAIT;
                    end else if (r_left_pend) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd       <= CMD_LEFT;
                        r_left_pend <= key_left;
                        r_fsm       <= FSM_WAIT;
                    end else if (r_right_pend) begin
                        r_cmd_valid  <= 1'b1;
                        r_cmd        <= CMD_RIGHT;
                        r_right_pend <= key_right;
                        r_fsm        <= FSM_WAIT;
                    end
                end

                FSM_WAIT: begin
`ifdef TETRIS_PAUSE_EN
                    if (key_start) begin
                        r_start_pend <= 1'b1;
                    end
`endif
                    if (w_rsp) begin
                        // A blocked move is a no-op; a blocked DOWN lands the piece
                        if ((r_cmd == CMD_DOWN) && !rsp_ok) begin
                            r_fsm <= FSM_LOCK;
                        end else begin
                            r_fsm <= FSM_IDLE;
                        end
                    end
                end

                FSM_LOCK: begin
                    if (!r_issued) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd       <= CMD_LOCK;
                        r_issued    <= 1'b1;
                    end else if (w_rsp) begin
                        r_issued <= 1'b0;
                        r_score  <= score_add(r_score, rsp_lines);
                        r_fsm    <= FSM_SPAWN;
                    end
                end

                FSM_OVER: begin
                    if (key_start) begin
                        r_fsm <= FSM_COVER;
                    end
                end

`ifdef TETRIS_PAUSE_EN
                FSM_PAUSED: begin
                    if (key_start) begin
                        r_fsm <= FSM_IDLE;
                    end
                end
`endif

                default: begin
                    r_fsm <= FSM_COVER;
                end
            endcase
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd       = r_cmd;
    assign state     = r_state;
    assign shape     = r_shape;
    assign score     = r_score;

endmodule

// File: tb/tb_tetris_flow_ctrl.sv
// Self-checking bench for tetris_flow_ctrl: directed game scenarios with
// randomized key mixes, handshake delays and line counts, checked against
// a behavioural model of command order and saturating score.
`timescale 1ns/1ps
module tb_tetris_flow_ctrl;

    localparam int DROP = 3;

    // Command codes as defined for the datapath interface
    localparam logic [2:0] C_RESET = 3'd0;
    localparam logic [2:0] C_SPAWN = 3'd1;
    localparam logic [2:0] C_LEFT  = 3'd2;
    localparam logic [2:0] C_RIGHT = 3'd3;
    localparam logic [2:0] C_ROT   = 3'd4;
    localparam logic [2:0] C_DOWN  = 3'd5;
    localparam logic [2:0] C_LOCK  = 3'd6;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_start, key_left, key_right, key_rot, key_down, frame_end;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic        cmd_ready, rsp_valid, rsp_ok;
    logic [2:0]  rsp_lines;
    logic [1:0]  state;
    logic [2:0]  shape;
    logic [15:0] score;

    always #5 clk = ~clk;

    tetris_flow_ctrl #(
        .DROP_FRAMES (DROP),
        .LFSR_SEED   (8'h01)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_start (key_start),
        .key_left  (key_left),
        .key_right (key_right),
        .key_rot   (key_rot),
        .key_down  (key_down),
        .frame_end (frame_end),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .rsp_valid (rsp_valid),
        .rsp_ok    (rsp_ok),
        .rsp_lines (rsp_lines),
        .state     (state),
        .shape     (shape),
        .score     (score)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          sat_bad = 0;
    logic [15:0] m_score;
    logic [2:0]  last_shape;
    int          points [5] = '{0, 1, 3, 5, 8};

    // Reference scoring rule: table lookup, >4 lines counts as 4, clamp at 0xFFFF
    function automatic logic [15:0] model_add(input logic [15:0] s, input int lines);
        int p;
        int t;
        p = points[(lines > 4) ? 4 : lines];
        t = int'(s) + p;
        return (t > 65535) ? 16'hFFFF : t[15:0];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic s, input logic l, input logic r, input logic ro, input logic d);
        key_start = s; key_left = l; key_right = r; key_rot = ro; key_down = d;
        tick();
        key_start = 0; key_left = 0; key_right = 0; key_rot = 0; key_down = 0;
    endtask

    task automatic wait_state(input string tag, input logic [1:0] exp);
        int w;
        w = 0;
        while (state !== exp && w < 20) begin
            tick();
            w++;
        end
        check(tag, {30'd0, state}, {30'd0, exp});
    endtask

    // Wait for a command, hold off ready, then accept and respond
    task automatic expect_cmd(input string tag, input logic [2:0] exp, input int ready_dly,
                              input int rsp_dly, input logic ok, input logic [2:0] lines);
        int   w;
        logic hold_bad;
        w = 0;
        hold_bad = 1'b0;
        while (cmd_valid !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        check({tag, "_seen"}, {31'd0, cmd_valid}, 32'd1);
        if (cmd_valid !== 1'b1) return;
        check({tag, "_cmd"}, {29'd0, cmd}, {29'd0, exp});
        for (int i = 0; i < ready_dly; i++) begin
            tick();
            if (cmd_valid !== 1'b1 || cmd !== exp) hold_bad = 1'b1;
        end
        if (ready_dly > 0) check({tag, "_hold"}, {31'd0, hold_bad}, 32'd0);
        cmd_ready = 1'b1;
        if (rsp_dly == 0) begin
            rsp_valid = 1'b1; rsp_ok = ok; rsp_lines = lines;
        end
        tick();
        cmd_ready = 1'b0; rsp_valid = 1'b0;
        check({tag, "_drop"}, {31'd0, cmd_valid}, 32'd0);
        if (rsp_dly > 0) begin
            for (int i = 1; i < rsp_dly; i++) tick();
            rsp_valid = 1'b1; rsp_ok = ok; rsp_lines = lines;
            tick();
            rsp_valid = 1'b0;
        end
    endtask

    task automatic expect_no_cmd(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (cmd_valid !== 1'b0) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd0);
    endtask

    // Lean same-cycle responder for the long score-saturation run
    task automatic fast_rsp(input logic [2:0] exp, input logic ok, input logic [2:0] lines, input logic kd);
        int w;
        w = 0;
        while (cmd_valid !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        if (cmd_valid !== 1'b1 || cmd !== exp) sat_bad++;
        cmd_ready = 1'b1; rsp_valid = 1'b1; rsp_ok = ok; rsp_lines = lines; key_down = kd;
        tick();
        cmd_ready = 1'b0; rsp_valid = 1'b0; key_down = 1'b0;
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] q[$];
        int         mask;
        int         lines;
        int         iters;

        rst = 1; key_start = 0; key_left = 0; key_right = 0; key_rot = 0; key_down = 0;
        frame_end = 0; cmd_ready = 0; rsp_valid = 0; rsp_ok = 0; rsp_lines = 0;
        repeat (3) tick();
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check("rst_cmd", {29'd0, cmd}, 32'd0);
        check("rst_shape", {29'd0, shape}, 32'd0);
        check("rst_score", {16'd0, score}, 32'd0);
        rst = 0;
        tick();
        $display("[TB] reset checked");

        // Game start: RESET_BOARD then SPAWN
        press(1, 0, 0, 0, 0);
        expect_cmd("t1_reset", C_RESET, 0, 0, 1'b1, 3'd0);
        expect_cmd("t1_spawn", C_SPAWN, 0, 0, 1'b1, 3'd0);
        m_score = 16'd0;
        wait_state("t1_state_play", 2'd1);
        check("t1_shape_range", {31'd0, (shape < 3'd7)}, 32'd1);
        check("t1_score", {16'd0, score}, {16'd0, m_score});
        last_shape = shape;
        $display("[TB] start: shape=%0d state=%0d", shape, state);

        // Gravity: one DOWN every DROP frame pulses
        repeat (DROP) begin
            frame_end = 1; tick(); frame_end = 0; tick();
        end
        expect_cmd("t2_drop1", C_DOWN, 0, 0, 1'b1, 3'd0);
        expect_no_cmd("t2_quiet", 8);
        repeat (DROP - 1) begin
            frame_end = 1; tick(); frame_end = 0; tick();
        end
        expect_no_cmd("t2_partial", 6);
        frame_end = 1; tick(); frame_end = 0;
        expect_cmd("t2_drop2", C_DOWN, 0, 0, 1'b1, 3'd0);
        $display("[TB] gravity: two DOWN commands at frame multiples of %0d", DROP);

        // Simultaneous left+right with a slow datapath
        press(0, 1, 1, 0, 0);
        expect_cmd("t3_left", C_LEFT, 4, 0, 1'b1, 3'd0);
        expect_cmd("t3_right", C_RIGHT, 0, 0, 1'b1, 3'd0);
        expect_no_cmd("t3_quiet", 4);
        $display("[TB] left/right: served in order");

        // Random key mixes: expected order down > rot > left > right
        for (int it = 0; it < 8; it++) begin
            mask = int'($urandom_range(1, 15));
            q = {};
            if (mask[3]) q.push_back(C_DOWN);
            if (mask[2]) q.push_back(C_ROT);
            if (mask[1]) q.push_back(C_LEFT);
            if (mask[0]) q.push_back(C_RIGHT);
            press(0, mask[1], mask[0], mask[2], mask[3]);
            foreach (q[k]) begin
                expect_cmd($sformatf("rnd%0d_%0d", it, k), q[k], int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 2)),
                           (q[k] == C_DOWN) ? 1'b1 : 1'($urandom_range(0, 1)), 3'd0);
            end
            expect_no_cmd($sformatf("rnd%0d_quiet", it), 3);
            $display("[TB] random keys mask=%0h -> %0d commands", mask, q.size());
        end
        check("rnd_shape_held", {29'd0, shape}, {29'd0, last_shape});

        // Landing: DOWN refused -> LOCK -> points -> SPAWN
        press(0, 0, 0, 0, 1);
        expect_cmd("t4_down", C_DOWN, 0, 0, 1'b0, 3'd0);
        expect_cmd("t4_lock", C_LOCK, 1, 0, 1'b1, 3'd4);
        m_score = model_add(m_score, 4);
        expect_cmd("t4_spawn", C_SPAWN, 0, 0, 1'b1, 3'd0);
        check("t4_score8", {16'd0, score}, {16'd0, m_score});
        for (int it = 0; it < 5; it++) begin
            lines = int'($urandom_range(0, 7));
            press(0, 0, 0, 0, 1);
            expect_cmd($sformatf("lk%0d_down", it), C_DOWN, 0, 0, 1'b0, 3'd0);
            expect_cmd($sformatf("lk%0d_lock", it), C_LOCK, int'($urandom_range(0, 2)),
                       int'($urandom_range(0, 2)), 1'b1, 3'(lines));
            m_score = model_add(m_score, lines);
            expect_cmd($sformatf("lk%0d_spawn", it), C_SPAWN, 0, 0, 1'b1, 3'd0);
            check($sformatf("lk%0d_score", it), {16'd0, score}, {16'd0, m_score});
            check($sformatf("lk%0d_shape", it), {31'd0, (shape < 3'd7)}, 32'd1);
            $display("[TB] lock lines=%0d score=%0h", lines, score);
        end

        // Drive the score to saturation with four-line locks
        press(0, 0, 0, 0, 1);
        iters = 0;
        while (m_score != 16'hFFFF && iters < 9000) begin
            fast_rsp(C_DOWN, 1'b0, 3'd0, 1'b0);
            fast_rsp(C_LOCK, 1'b1, 3'd4, 1'b1);
            m_score = model_add(m_score, 4);
            fast_rsp(C_SPAWN, 1'b1, 3'd0, 1'b0);
            iters++;
        end
        check("sat_cmd_seq", sat_bad, 32'd0);
        check("sat_score", {16'd0, score}, 32'h0000FFFF);
        expect_cmd("sat_down", C_DOWN, 0, 0, 1'b0, 3'd0);
        expect_cmd("sat_lock", C_LOCK, 0, 0, 1'b1, 3'd1);
        expect_cmd("sat_spawn", C_SPAWN, 0, 0, 1'b1, 3'd0);
        check("sat_hold", {16'd0, score}, 32'h0000FFFF);
        $display("[TB] saturation after %0d locks: score=%0h", iters, score);

        // Spawn collision ends the game; keys are dead until key_start
        press(0, 0, 0, 0, 1);
        expect_cmd("t5_down", C_DOWN, 0, 0, 1'b0, 3'd0);
        expect_cmd("t5_lock", C_LOCK, 0, 0, 1'b1, 3'd0);
        expect_cmd("t5_spawn", C_SPAWN, 0, 0, 1'b0, 3'd0);
        wait_state("t5_state_end", 2'd2);
        press(0, 1, 1, 1, 1);
        frame_end = 1; tick(); tick(); tick(); frame_end = 0;
        expect_no_cmd("t5_no_cmd", 12);
        check("t5_score_kept", {16'd0, score}, 32'h0000FFFF);
        press(1, 0, 0, 0, 0);
        wait_state("t5_state_cover", 2'd0);
        expect_no_cmd("t5_cover_quiet", 4);
        $display("[TB] game over and back to cover");

        // Reset in the middle of a handshake; late response ignored
        press(1, 0, 0, 0, 0);
        iters = 0;
        while (cmd_valid !== 1'b1 && iters < 20) begin
            tick();
            iters++;
        end
        check("t6_pending_cmd", {29'd0, cmd}, {29'd0, C_RESET});
        tick(); tick();
        rst = 1;
        tick();
        rst = 0;
        check("t6_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check("t6_state", {30'd0, state}, 32'd0);
        check("t6_score", {16'd0, score}, 32'd0);
        rsp_valid = 1; rsp_ok = 1; cmd_ready = 1;
        tick();
        rsp_valid = 0; cmd_ready = 0;
        expect_no_cmd("t6_late_rsp", 8);
        check("t6_state_after", {30'd0, state}, 32'd0);
        press(1, 0, 0, 0, 0);
        expect_cmd("t6_restart", C_RESET, 0, 0, 1'b1, 3'd0);
        expect_cmd("t6_respawn", C_SPAWN, 0, 1, 1'b1, 3'd0);
        wait_state("t6_play", 2'd1);
        $display("[TB] reset mid-handshake recovered");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
